// File: rtl/serial_exec_sequencer.sv
// serial_exec_sequencer: LOAD/EXEC/DONE control for the 8-bit bit-serial datapath.
// Define SEQ_STEP_MODE_EN to add a step input that advances EXEC one bit per pulse.
module serial_exec_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rstn,
`ifdef SEQ_STEP_MODE_EN
  input  logic          step,
`endif
  input  logic          start,
  input  logic [3:0]    opcode,
  output logic          load_a,
  output logic          load_b,
  output logic          load_out,
  output logic          shift_a,
  output logic          shift_b,
  output logic          shift_out,
  output logic [1:0]    alu_op,
  output logic          carry_clr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] bit_idx
);
  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    op_q;
  logic          load_q, exec_q, done_q, err_q;
  logic          adv;
  logic          last;
`ifdef SEQ_STEP_MODE_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif
  assign last = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      load_q  <= 1'b0;
      exec_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && opcode[3:2] == 2'b00) begin
            state_q <= LOAD;
            op_q    <= opcode[1:0];
            load_q  <= 1'b1;
          end else begin
            err_q <= start;
          end
        end
        LOAD: begin
          state_q <= EXEC;
          exec_q  <= 1'b1;
          cnt_q   <= '0;
        end
        EXEC: begin
          if (adv && last) begin
            state_q <= DONE;
            exec_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (adv) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          op_q    <= '0;
        end
      endcase
    end
  end
  // bit counter is held at zero outside EXEC, so it doubles as bit_idx
  assign load_a    = load_q;
  assign load_b    = load_q;
  assign load_out  = load_q;
  assign carry_clr = load_q;
  assign shift_a   = exec_q & adv;
  assign shift_b   = exec_q & adv;
  assign shift_out = exec_q & adv;
  assign alu_op    = op_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign err       = err_q;
  assign bit_idx   = cnt_q;
endmodule

// File: doc/serial_exec_sequencer.md
Name: serial_exec_sequencer

Overview:
- Control sequencer for the 8-bit bit-serial datapath (A/B shift registers, 1-bit ALU, carry flop, OUT shift register).
- On a start pulse it latches the opcode and issues one parallel-load cycle.
- It then runs WIDTH shift/ALU cycles and reports completion with a done pulse.
- It replaces ad-hoc counter/FSM glue with a single handshake-driven block sitting between button/decoder logic and the datapath.

Parameters:
- WIDTH, 8, number of serial bit cycles per operation (operand width); must be >= 2.
- CW, 4, bit-counter width; must satisfy 2**CW >= WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  synchronous active-low reset
- start  input  1  one-cycle request pulse (e.g. debounced button edge)
- opcode  input  4  operation code, sampled only when start is accepted
- load_a  output  1  parallel-load A register
- load_b  output  1  parallel-load B register
- load_out  output  1  parallel-load (clear) OUT register
- shift_a  output  1  shift A right one bit
- shift_b  output  1  shift B right one bit
- shift_out  output  1  shift ALU result bit into OUT
- alu_op  output  2  ALU function select, held from LOAD through DONE
- carry_clr  output  1  clear carry flop this cycle
- busy  output  1  high from LOAD through DONE inclusive
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse on illegal opcode
- bit_idx  output  CW  current bit index during EXEC, 0 otherwise

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, counter=0, latched op=0. All outputs 0, including alu_op=00. Reset mid-operation aborts immediately with no done pulse.
- Opcode decode:
  - opcode[3:2]==2'b00 is legal; alu_op = opcode[1:0].
  - Any other value is illegal: no datapath strobes, err pulses for 1 cycle in the cycle after start, state stays IDLE.
- States: IDLE, LOAD, EXEC, DONE (registered, one-hot or binary).
- IDLE:
  - All strobes 0.
  - start=1 with legal opcode -> LOAD next cycle, opcode latched.
- LOAD (1 cycle):
  - load_a=load_b=load_out=carry_clr=1; counter cleared to 0.
  - -> EXEC.
- EXEC (exactly WIDTH cycles):
  - shift_a=shift_b=shift_out=1; bit_idx=counter; counter increments each cycle.
  - When counter==WIDTH-1 -> DONE.
- DONE (1 cycle):
  - done=1, busy=1, no strobes.
  - -> IDLE.
- Latency: start accepted at cycle N -> LOAD at N+1, EXEC N+2..N+1+WIDTH, done at N+2+WIDTH. Next start is accepted at N+3+WIDTH or later.
- start while busy=1 is ignored (not queued). opcode changes during busy have no effect.
- Load and shift strobes are never asserted in the same cycle.
- carry_clr is only asserted in LOAD.

Optional Feature:
- Macro SEQ_STEP_MODE_EN.
- Defined:
  - Adds input port step (1 bit).
  - In EXEC, shift strobes and the counter increment occur only in cycles where step=1; otherwise all strobes are 0 and state holds.
  - LOAD and DONE are unaffected; each step pulse advances exactly one bit.
  - step in IDLE/LOAD/DONE is ignored.
- Undefined: no step port; EXEC runs free as above.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0.
- opcode=4'h1, start pulse at cycle 0:
  - cycle 1: load_a/load_b/load_out/carry_clr=1, alu_op=01.
  - cycles 2-9: shift strobes=1, bit_idx 0..7.
  - cycle 10: done=1.
  - cycle 11: busy=0.
- start pulses at cycles 3 and 6 of an active operation -> ignored; exactly one done; total shift cycles=8.
- opcode=4'h5 with start -> err=1 next cycle, no load/shift strobes, busy stays 0.
- Assert rstn=0 during EXEC at bit_idx=4 -> next cycle all outputs 0, state IDLE, no done. A fresh start then runs a full 8 bits.
- SEQ_STEP_MODE_EN defined: start, then step pulses spaced 3 cycles apart -> exactly one shift strobe per step. done follows the cycle after the 8th stepped shift.
